multi_alarm_ctrl: RTL and testbench

MULTI_ALARM_CTRL -- requirements
Module: multi_alarm_ctrl

---
 rtl/alarm_pkg.sv | 50 +++++
 rtl/bcd_time_add.sv | 56 +++++
 rtl/multi_alarm_ctrl.sv | 170 +++++++++++++++++
 tb/tb_multi_alarm_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// ============================================================================
// Module      : alarm_pkg
// Description : Shared types, BCD limits and BCD/binary helpers for the
//               multi-channel alarm controller.
// Contents    : bcd_time_t   - packed {hour tens, hour ones, min tens, min ones}
//               alm_state_e  - per-channel alarm state
//               c_HOUR_MAX / c_MIN_MAX - BCD wrap limits (23, 59)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

    typedef struct packed {
        logic [3:0] hour_tens;
        logic [3:0] hour_ones;
        logic [3:0] min_tens;
        logic [3:0] min_ones;
    } bcd_time_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RINGING = 3'd2,
        ST_SNOOZED = 3'd3,
        ST_DONE    = 3'd4
    } alm_state_e;

    localparam logic [7:0] c_HOUR_MAX = 8'd23;
    localparam logic [7:0] c_MIN_MAX  = 8'd59;

    // Two BCD digits to binary (0..99 for valid digits, 0..165 otherwise).
    function automatic logic [7:0] bcd_to_bin(input logic [3:0] tens,
                                              input logic [3:0] ones);
        return ({4'd0, tens} * 8'd10) + {4'd0, ones};
    endfunction

    // Binary to two BCD digits {tens, ones}; inputs above 99 still yield
    // defined (if meaningless) digits, so garbage in never produces X out.
    function automatic logic [7:0] bin_to_bcd(input logic [7:0] val);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(val / 8'd10);
        ones = 4'(val - ({4'd0, tens} * 8'd10));
        return {tens, ones};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_time_add.sv
// ============================================================================
// Module      : bcd_time_add
// Description : Combinational BCD clock adder: time + minutes (0..59).
//               Minutes wrap 59->00 with a carry into hours, hours wrap
//               23->00 (23:58 + 5 = 00:03).
// Ports       : time_i    [15:0] packed BCD time in
//               add_min_i [5:0]  binary minutes to add
//               time_o    [15:0] packed BCD result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_time_add
    import alarm_pkg::*;
(
    input  logic [15:0] time_i,
    input  logic [5:0]  add_min_i,
    output logic [15:0] time_o
);

    bcd_time_t  w_in;
    bcd_time_t  w_out;
    logic [7:0] w_min_sum;
    logic [7:0] w_hr_sum;
    logic       w_carry;
    logic [7:0] w_min_bcd;
    logic [7:0] w_hr_bcd;

    assign w_in = bcd_time_t'(time_i);

    // Work in binary, then convert back; simpler than digit-wise BCD carries.
    always_comb begin
        w_min_sum = bcd_to_bin(w_in.min_tens, w_in.min_ones) + {2'd0, add_min_i};
        w_carry   = (w_min_sum > c_MIN_MAX);
        if (w_carry) begin
            w_min_sum = w_min_sum - (c_MIN_MAX + 8'd1);
        end

        w_hr_sum = bcd_to_bin(w_in.hour_tens, w_in.hour_ones) + {7'd0, w_carry};
        if (w_hr_sum > c_HOUR_MAX) begin
            w_hr_sum = w_hr_sum - (c_HOUR_MAX + 8'd1);
        end

        w_min_bcd       = bin_to_bcd(w_min_sum);
        w_hr_bcd        = bin_to_bcd(w_hr_sum);
        w_out.hour_tens = w_hr_bcd[7:4];
        w_out.hour_ones = w_hr_bcd[3:0];
        w_out.min_tens  = w_min_bcd[7:4];
        w_out.min_ones  = w_min_bcd[3:0];
    end

    assign time_o = 16'(w_out);

endmodule

`default_nettype wire

// File: rtl/multi_alarm_ctrl.sv
// ============================================================================
// Module      : multi_alarm_ctrl
// Description : N independent alarm channels, each with its own FSM
//               (IDLE/ARMED/RINGING/SNOOZED/DONE), ring timeout, BCD snooze
//               and snooze limit. Shared off/snooze buttons act on every
//               ringing channel at once.
// Ports       : clk, rst           clock, async active-high reset
//               sec_tick           1 Hz one-cycle strobe
//               now_time [15:0]    current BCD time
//               alm_time [16N-1:0] per-channel BCD alarm times
//               alm_en   [N-1:0]   per-channel arm enables
//               off_btn, snooze_btn one-cycle button strobes
//               aud_en             sound enable (any channel ringing)
//               ringing  [N-1:0]   per-channel ringing flags
//               ring_id  [2:0]     lowest ringing channel index
//               snoozed  [N-1:0]   per-channel snoozed flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int N_ALARMS   = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sec_tick,
    input  logic [15:0]           now_time,
    input  logic [16*N_ALARMS-1:0] alm_time,
    input  logic [N_ALARMS-1:0]   alm_en,
    input  logic                  off_btn,
    input  logic                  snooze_btn,
    output logic                  aud_en,
    output logic [N_ALARMS-1:0]   ringing,
    output logic [2:0]            ring_id,
    output logic [N_ALARMS-1:0]   snoozed
);

    localparam logic [7:0] c_RING_LAST  = 8'(RING_SEC - 1);
    localparam logic [2:0] c_SNOOZE_MAX = 3'(MAX_SNOOZE);
    localparam logic [5:0] c_SNOOZE_ADD = 6'(SNOOZE_MIN);

    logic [15:0]         w_snooze_time;
    logic [N_ALARMS-1:0] w_ring_vec;
    logic [N_ALARMS-1:0] w_snz_vec;

    // Every channel snoozes to the same "now + SNOOZE_MIN", so one adder
    // serves all of them.
    bcd_time_add u_snooze_add (
        .time_i    (now_time),
        .add_min_i (c_SNOOZE_ADD),
        .time_o    (w_snooze_time)
    );

    for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_ch
        alm_state_e  state_q;
        logic [15:0] target_q;
        logic [7:0]  ring_cnt_q;
        logic [2:0]  snz_cnt_q;
        logic        ring_q;
        logic        snz_q;
        logic [15:0] w_alm;

        assign w_alm = alm_time[16*gi +: 16];

        // Output flags are written alongside each state transition so they
        // appear on the same edge as the state change.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= ST_IDLE;
                target_q   <= '0;
                ring_cnt_q <= '0;
                snz_cnt_q  <= '0;
                ring_q     <= 1'b0;
                snz_q      <= 1'b0;
            end else if (!alm_en[gi]) begin
                state_q <= ST_IDLE;
                ring_q  <= 1'b0;
                snz_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q  <= ST_ARMED;
                        target_q <= w_alm;
                    end
                    ST_ARMED: begin
                        // Tracks alm_time so edits while armed take effect.
                        target_q <= w_alm;
                        if (now_time == target_q) begin
                            state_q    <= ST_RINGING;
                            ring_q     <= 1'b1;
                            ring_cnt_q <= '0;
                            snz_cnt_q  <= '0;
                        end
                    end
                    ST_RINGING: begin
                        if (off_btn) begin
                            state_q <= ST_DONE;
                            ring_q  <= 1'b0;
                        end else if (snooze_btn) begin
                            ring_q <= 1'b0;
                            if (snz_cnt_q < c_SNOOZE_MAX) begin
                                state_q   <= ST_SNOOZED;
                                snz_q     <= 1'b1;
                                target_q  <= w_snooze_time;
                                snz_cnt_q <= snz_cnt_q + 3'd1;
                            end else begin
                                state_q <= ST_DONE;
                            end
                        end else if (sec_tick) begin
                            if (ring_cnt_q == c_RING_LAST) begin
                                state_q <= ST_DONE;
                                ring_q  <= 1'b0;
                            end else begin
                                ring_cnt_q <= ring_cnt_q + 8'd1;
                            end
                        end
                    end
                    ST_SNOOZED: begin
                        if (off_btn) begin
                            state_q <= ST_DONE;
                            snz_q   <= 1'b0;
                        end else if (now_time == target_q) begin
                            state_q    <= ST_RINGING;
                            ring_q     <= 1'b1;
                            snz_q      <= 1'b0;
                            ring_cnt_q <= '0;
                        end
                    end
                    ST_DONE: begin
                        // Wait out the alarm minute so it cannot retrigger.
                        if (now_time != w_alm) begin
                            state_q  <= ST_ARMED;
                            target_q <= w_alm;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        ring_q  <= 1'b0;
                        snz_q   <= 1'b0;
                    end
                endcase
            end
        end

        assign w_ring_vec[gi] = ring_q;
        assign w_snz_vec[gi]  = snz_q;
    end

    // Decoded straight from the channel flops: no extra cycle of latency.
    always_comb begin
        ring_id = 3'd0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (w_ring_vec[i]) begin
                ring_id = 3'(i);
            end
        end
    end

    assign aud_en  = |w_ring_vec;
    assign ringing = w_ring_vec;
    assign snoozed = w_snz_vec;

endmodule

`default_nettype wire

// File: tb/tb_multi_alarm_ctrl.sv
// ============================================================================
// Module      : tb_multi_alarm_ctrl
// Description : Directed self-checking bench for multi_alarm_ctrl (4 channels,
//               5 min snooze, 60 s ring, 3 snoozes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_alarm_ctrl;

    logic        clk;
    logic        rst;
    logic        sec_tick;
    logic [15:0] now_time;
    logic [63:0] alm_time;
    logic [3:0]  alm_en;
    logic        off_btn;
    logic        snooze_btn;
    logic        aud_en;
    logic [3:0]  ringing;
    logic [2:0]  ring_id;
    logic [3:0]  snoozed;

    int n_checks = 0;
    int n_fail   = 0;

    multi_alarm_ctrl #(
        .N_ALARMS   (4),
        .SNOOZE_MIN (5),
        .RING_SEC   (60),
        .MAX_SNOOZE (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .now_time   (now_time),
        .alm_time   (alm_time),
        .alm_en     (alm_en),
        .off_btn    (off_btn),
        .snooze_btn (snooze_btn),
        .aud_en     (aud_en),
        .ringing    (ringing),
        .ring_id    (ring_id),
        .snoozed    (snoozed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick();
        sec_tick = 1'b1;
        step(1);
        sec_tick = 1'b0;
        step(1);
    endtask

    task automatic pulse_snooze();
        snooze_btn = 1'b1;
        step(1);
        snooze_btn = 1'b0;
    endtask

    task automatic pulse_off();
        off_btn = 1'b1;
        step(1);
        off_btn = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        sec_tick   = 1'b0;
        now_time   = 16'h0000;
        alm_time   = '0;
        alm_en     = 4'b0000;
        off_btn    = 1'b0;
        snooze_btn = 1'b0;
        step(2);
        chk("rst_aud",     16'(aud_en),  16'h0);
        chk("rst_ringing", 16'(ringing), 16'h0);
        chk("rst_ring_id", 16'(ring_id), 16'h0);
        chk("rst_snoozed", 16'(snoozed), 16'h0);
        rst = 1'b0;

        // ---- ch0 07:30: ring, timeout, no retrigger, re-arm ----
        alm_time[15:0] = 16'h0730;
        alm_en         = 4'b0001;
        now_time       = 16'h0729;
        step(2);
        chk("a_pre_ring", 16'(ringing), 16'h0);
        now_time = 16'h0730;
        step(1);
        chk("a_ring",     16'(ringing), 16'h1);
        chk("a_aud",      16'(aud_en),  16'h1);
        chk("a_ring_id",  16'(ring_id), 16'h0);
        for (int i = 0; i < 59; i++) pulse_tick();
        chk("a_tick59_ring", 16'(ringing), 16'h1);
        pulse_tick();
        chk("a_tick60_ring", 16'(ringing), 16'h0);
        chk("a_tick60_aud",  16'(aud_en),  16'h0);
        step(5);
        chk("a_no_retrigger", 16'(ringing), 16'h0);
        now_time = 16'h0731;
        step(2);
        chk("a_0731_quiet", 16'(ringing), 16'h0);
        now_time = 16'h0730;
        step(1);
        chk("a_rearmed_ring", 16'(ringing), 16'h1);
        pulse_off();
        chk("a_off", 16'(ringing), 16'h0);

        // ---- ch1 23:58: snooze wraps midnight to 00:03 ----
        alm_time[31:16] = 16'h2358;
        alm_en          = 4'b0010;
        now_time        = 16'h2357;
        step(2);
        now_time = 16'h2358;
        step(1);
        chk("b_ring",    16'(ringing), 16'h2);
        chk("b_ring_id", 16'(ring_id), 16'h1);
        pulse_snooze();
        chk("b_snoozed",   16'(snoozed), 16'h2);
        chk("b_snz_aud",   16'(aud_en),  16'h0);
        chk("b_snz_ring",  16'(ringing), 16'h0);
        now_time = 16'h0002;
        step(2);
        chk("b_0002_quiet", 16'(ringing), 16'h0);
        now_time = 16'h0003;
        step(1);
        chk("b_0003_ring",    16'(ringing), 16'h2);
        chk("b_0003_snoozed", 16'(snoozed), 16'h0);
        pulse_off();
        chk("b_off", 16'(aud_en), 16'h0);

        // ---- ch2 11:55: three snoozes allowed, fourth ends it ----
        alm_time[47:32] = 16'h1155;
        alm_en          = 4'b0100;
        now_time        = 16'h1154;
        step(2);
        now_time = 16'h1155;
        step(1);
        chk("c_ring0", 16'(ringing), 16'h4);
        chk("c_ring_id", 16'(ring_id), 16'h2);
        pulse_snooze();
        chk("c_snz1", 16'(snoozed), 16'h4);
        now_time = 16'h1200;
        step(1);
        chk("c_ring1", 16'(ringing), 16'h4);
        pulse_snooze();
        now_time = 16'h1205;
        step(1);
        chk("c_ring2", 16'(ringing), 16'h4);
        pulse_snooze();
        chk("c_snz3", 16'(snoozed), 16'h4);
        now_time = 16'h1210;
        step(1);
        chk("c_ring3", 16'(ringing), 16'h4);
        pulse_snooze();
        chk("c_snz4_ring",    16'(ringing), 16'h0);
        chk("c_snz4_snoozed", 16'(snoozed), 16'h0);
        now_time = 16'h1215;
        step(2);
        chk("c_1215_quiet", 16'(ringing), 16'h0);

        // ---- ch0 + ch3 same time, both buttons together ----
        alm_time[15:0]  = 16'h0645;
        alm_time[63:48] = 16'h0645;
        alm_en          = 4'b1001;
        now_time        = 16'h0644;
        step(2);
        now_time = 16'h0645;
        step(1);
        chk("d_ring",    16'(ringing), 16'h9);
        chk("d_ring_id", 16'(ring_id), 16'h0);
        chk("d_aud",     16'(aud_en),  16'h1);
        off_btn    = 1'b1;
        snooze_btn = 1'b1;
        step(1);
        off_btn    = 1'b0;
        snooze_btn = 1'b0;
        chk("d_both_ring",    16'(ringing), 16'h0);
        chk("d_both_snoozed", 16'(snoozed), 16'h0);

        // ---- enable drop, async reset mid-ring, ring after release ----
        alm_en   = 4'b0001;
        now_time = 16'h0646;
        step(2);
        now_time = 16'h0645;
        step(1);
        chk("e_ring", 16'(ringing), 16'h1);
        alm_en = 4'b0000;
        step(1);
        chk("e_en_drop_ring", 16'(ringing), 16'h0);
        chk("e_en_drop_aud",  16'(aud_en),  16'h0);
        alm_en   = 4'b0001;
        now_time = 16'h0644;
        step(2);
        now_time = 16'h0645;
        step(1);
        chk("e_ring_again", 16'(ringing), 16'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("e_async_aud",     16'(aud_en),  16'h0);
        chk("e_async_ringing", 16'(ringing), 16'h0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("e_release_armed", 16'(ringing), 16'h0);
        step(1);
        chk("e_release_ring",  16'(ringing), 16'h1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
